// File: rtl/mux_sel_scanner_if.sv
// Bus between the channel-mux scan sequencer and its environment: scan control,
// the mux select/output pair and the per-frame snapshot.
interface mux_sel_scanner_if #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [3:0]         chan_mask;
  logic [DWELL_W-1:0] dwell;
  logic               mux_y;
  logic [1:0]         sel;
  logic               busy;
  logic [3:0]         samples;
  logic               frame_valid;
  logic [CNT_W-1:0]   frame_cnt;

  modport master (
    input  start, stop, continuous, chan_mask, dwell, mux_y,
    output sel, busy, samples, frame_valid, frame_cnt
  );

  modport slave (
    output start, stop, continuous, chan_mask, dwell, mux_y,
    input  sel, busy, samples, frame_valid, frame_cnt
  );
endinterface

// File: rtl/mux_sel_scanner.sv
// Sequencer stepping a 4-to-1 mux through enabled channels and snapshotting mux_y per frame.
// Optional macro SCAN_MAJORITY_EN: per-channel bit is the majority of the last 3 dwell samples.
module mux_sel_scanner #(
  parameter int SETTLE  = 2,
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sel_scanner_if.master    bus
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DWELL  = 2'd2
  } state_t;

  // Phase counter must hold both SETTLE-1 (up to 14) and dwell_q-1.
  localparam int CW = (DWELL_W > 4) ? DWELL_W : 4;

  // {found, index} of the lowest enabled channel whose index is >= lo.
  function automatic logic [2:0] next_chan(input logic [3:0] mask, input int lo);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k] && (k >= lo)) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
`ifdef SCAN_MAJORITY_EN
    return (d < DWELL_W'(3)) ? DWELL_W'(3) : d;
`else
    return (d == '0) ? DWELL_W'(1) : d;
`endif
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [1:0]         sel_q, sel_n;
  logic [3:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         shadow, shadow_upd;
  logic [3:0]         samples_q;
  logic               busy_q;
  logic               fv_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic               load, sample, commit;
  logic               cur_bit;
  logic [2:0]         nxt, first;
`ifdef SCAN_MAJORITY_EN
  logic [1:0]         hist;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state, phase counter and datapath strobes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_q;
    load    = 1'b0;
    sample  = 1'b0;
    commit  = 1'b0;
`ifdef SCAN_MAJORITY_EN
    cur_bit = maj3(hist[1], hist[0], bus.mux_y);
`else
    cur_bit = bus.mux_y;
`endif
    shadow_upd        = shadow;
    shadow_upd[sel_q] = cur_bit;
    nxt   = next_chan(mask_q, int'(sel_q) + 1);
    first = next_chan(bus.chan_mask, 0);
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.stop && first[2]) begin
          load    = 1'b1;
          sel_n   = first[1:0];
          cnt_n   = CW'(SETTLE - 1);
          state_n = S_SETTLE;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (bus.stop) begin
          state_n = S_IDLE;
        end else if (cnt == '0) begin
          cnt_n   = CW'(dwell_q) - CW'(1);
          state_n = S_DWELL;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_DWELL: begin
        if (bus.stop) begin
          state_n = S_IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          sample = 1'b1;
          if (nxt[2]) begin
            sel_n   = nxt[1:0];
            cnt_n   = CW'(SETTLE - 1);
            state_n = S_SETTLE;
          end else begin
            commit = 1'b1;
            // Continuous rescans re-latch mask/dwell; a zero mask parks in IDLE.
            if (bus.continuous && first[2]) begin
              load    = 1'b1;
              sel_n   = first[1:0];
              cnt_n   = CW'(SETTLE - 1);
              state_n = S_SETTLE;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sel_q       <= 2'd0;
      mask_q      <= 4'd0;
      dwell_q     <= '0;
      shadow      <= 4'd0;
      samples_q   <= 4'd0;
      busy_q      <= 1'b0;
      fv_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      cnt    <= cnt_n;
      sel_q  <= sel_n;
      busy_q <= (state_n != S_IDLE);
      fv_q   <= commit;
      if (commit) begin
        samples_q   <= shadow_upd;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if (load) begin
        mask_q  <= bus.chan_mask;
        dwell_q <= eff_dwell(bus.dwell);
        shadow  <= 4'd0;
      end else if (sample) begin
        shadow <= shadow_upd;
      end
    end
  end

`ifdef SCAN_MAJORITY_EN
  // History of mux_y over the dwell cycles preceding the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 hist <= 2'b00;
    else if (state == S_DWELL)  hist <= {hist[0], bus.mux_y};
  end
`endif

  assign bus.sel         = sel_q;
  assign bus.busy        = busy_q;
  assign bus.samples     = samples_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_cnt   = frame_cnt_q;
endmodule
